fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_rd_skid.sv | 102 ++++++++++
 rtl/fifo_stream_reader.sv | 163 ++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the sync_fifo stream reader: reader FSM state
// encoding, the default data width and the width of the transfer counter.
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Default data width, matches the sync_fifo default.
    localparam int unsigned FIFO_WIDTH_DEF = 8;

    // Width of the wrapping transfer counter.
    localparam int unsigned WORD_COUNT_W   = 16;

    // Reader state machine encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage : fifo_pkg

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry in-order buffer for words returned by the sync_fifo. Slot 0 is
// always the head. Push and pop in the same cycle both take effect.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset (discards contents)
//   i_push       in   write i_push_data at the tail
//   i_push_data  in   word to write
//   i_pop        in   remove the head word
//   o_head_data  out  head word
//   o_head_valid out  buffer holds at least one word
//   o_count      out  number of words held (0..2)
// -----------------------------------------------------------------------------
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_head_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic [1:0]       r_count;

    logic [WIDTH-1:0] w_slot0_nxt;
    logic [WIDTH-1:0] w_slot1_nxt;
    logic [1:0]       w_count_nxt;

    // Next-state of the two slots and the occupancy for every push/pop mix.
    always_comb begin
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        w_count_nxt = r_count;
        case ({i_push, i_pop})
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_slot0_nxt = i_push_data;
                    w_count_nxt = 2'd1;
                end else if (r_count == 2'd1) begin
                    w_slot1_nxt = i_push_data;
                    w_count_nxt = 2'd2;
                end else begin
                    // Full: the credit logic upstream never lets this happen.
                    w_count_nxt = r_count;
                end
            end
            2'b01: begin
                if (r_count == 2'd2) begin
                    w_slot0_nxt = r_slot1;
                    w_count_nxt = 2'd1;
                end else if (r_count == 2'd1) begin
                    w_count_nxt = 2'd0;
                end else begin
                    w_count_nxt = r_count;
                end
            end
            2'b11: begin
                // Occupancy is unchanged when holding two; the new word goes
                // behind the surviving one. Otherwise it becomes the head.
                if (r_count == 2'd2) begin
                    w_slot0_nxt = r_slot1;
                    w_slot1_nxt = i_push_data;
                    w_count_nxt = 2'd2;
                end else begin
                    w_slot0_nxt = i_push_data;
                    w_count_nxt = 2'd1;
                end
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot0 <= {WIDTH{1'b0}};
            r_slot1 <= {WIDTH{1'b0}};
            r_count <= 2'd0;
        end else begin
            r_slot0 <= w_slot0_nxt;
            r_slot1 <= w_slot1_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_head_data  = r_slot0;
    assign o_head_valid = (r_count != 2'd0);
    assign o_count      = r_count;

endmodule : fifo_rd_skid

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Pulls words from a sync_fifo (registered read data, one cycle after the read
// strobe) and presents them as a valid/ready stream with m_last marking the
// final word of each BURST_LEN burst.
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   enable        in   allow new FIFO reads
//   fifo_empty    in   sync_fifo empty flag
//   fifo_rd_data  in   sync_fifo read data (valid the cycle after fifo_rd_en)
//   fifo_rd_en    out  sync_fifo read strobe
//   m_valid       out  output word valid
//   m_data        out  output word
//   m_last        out  last word of a burst
//   m_ready       in   downstream accept
//   busy          out  state machine not idle
//   word_count    out  wrapping count of transferred words
// -----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH_DEF,
    parameter int BURST_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [WIDTH-1:0]        fifo_rd_data,
    output logic                    fifo_rd_en,
    output logic                    m_valid,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_last,
    input  logic                    m_ready,
    output logic                    busy,
    output logic [WORD_COUNT_W-1:0] word_count
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    rd_state_e               r_state;
    rd_state_e               w_state_nxt;
    logic                    r_inflight;
    logic [BEAT_W-1:0]       r_beat;
    logic [WORD_COUNT_W-1:0] r_word_count;

    logic [WIDTH-1:0]        w_head_data;
    logic                    w_head_valid;
    logic [1:0]              w_count;
    logic                    w_pop;
    logic [2:0]              w_credit;
    logic                    w_rd_en;
    logic                    w_pending;

    fifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (r_inflight),
        .i_push_data  (fifo_rd_data),
        .i_pop        (w_pop),
        .o_head_data  (w_head_data),
        .o_head_valid (w_head_valid),
        .o_count      (w_count)
    );

    assign w_pop     = w_head_valid && m_ready;
    assign w_pending = (w_count != 2'd0) || r_inflight;

    // Words that will occupy the buffer next cycle without a new read; a pop
    // only happens with a buffered word, so this never goes negative.
    assign w_credit  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // The state term keeps the strobe low in reset, IDLE and DRAIN.
    assign w_rd_en   = (r_state == ST_RUN) && enable && !fifo_empty && (w_credit < 3'd2);

    // Reader state machine transitions.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    w_state_nxt = ST_RUN;
                end else if (w_pending) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    w_state_nxt = ST_RUN;
                end else if (!w_pending) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A read sampled on this edge returns its word on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    // Beat position of the head word within its burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= {BEAT_W{1'b0}};
        end else if (w_pop) begin
            if (r_beat == BEAT_LAST) begin
                r_beat <= {BEAT_W{1'b0}};
            end else begin
                r_beat <= r_beat + {{(BEAT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Wrapping transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= {WORD_COUNT_W{1'b0}};
        end else if (w_pop) begin
            r_word_count <= r_word_count + {{(WORD_COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = w_head_valid;
    assign m_data     = w_head_data;
    assign m_last     = w_head_valid && (r_beat == BEAT_LAST);
    assign busy       = (r_state != ST_IDLE);
    assign word_count = r_word_count;

endmodule : fifo_stream_reader

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Directed bench: a small sync_fifo model feeds the reader, a monitor logs
// every transfer, and one initial block walks through reset, streaming,
// backpressure, drain, empty/wrap and reset-mid-burst scenarios.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int W  = 8;
    localparam int BL = 4;

    logic         clk          = 1'b0;
    logic         rst_n        = 1'b0;
    logic         enable       = 1'b0;
    logic         m_ready      = 1'b0;
    logic         fifo_empty;
    logic [W-1:0] fifo_rd_data = '0;
    logic         fifo_rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         busy;
    logic [15:0]  word_count;

    int total = 0;
    int bad   = 0;

    fifo_stream_reader #(
        .WIDTH     (W),
        .BURST_LEN (BL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .busy         (busy),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    // sync_fifo model: registered read data, monotonically advancing pointers.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
        end
    end

    // Transfer monitor and read-while-empty detector.
    int         cyc   = 0;
    int         log_n = 0;
    logic [7:0] log_d [0:63];
    logic       log_l [0:63];
    int         log_c [0:63];
    logic       rd_empty_seen = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && fifo_empty) rd_empty_seen <= 1'b1;
        if (m_valid && m_ready && log_n < 64) begin
            log_d[log_n] <= m_data;
            log_l[log_n] <= m_last;
            log_c[log_n] <= cyc;
            log_n        <= log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic wait_log(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (log_n < target && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(log_n >= target), 32'd1);
    endtask

    logic [7:0] exp_s [0:4];
    logic [7:0] exp_r [0:3];
    int         base;
    logic [7:0] rp0;
    logic       found;

    initial begin
        exp_s[0] = 8'h24; exp_s[1] = 8'h81; exp_s[2] = 8'h09; exp_s[3] = 8'h63; exp_s[4] = 8'h0D;
        exp_r[0] = 8'hA1; exp_r[1] = 8'hB2; exp_r[2] = 8'hC3; exp_r[3] = 8'hD4;

        // Reset held with data available and enable high.
        rst_n = 1'b0; enable = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(exp_s[i]);
        tick(3);
        chk("rst_rd_en",  32'(fifo_rd_en), 32'd0);
        chk("rst_valid",  32'(m_valid),    32'd0);
        chk("rst_data",   32'(m_data),     32'd0);
        chk("rst_last",   32'(m_last),     32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_wcount", 32'(word_count), 32'd0);
        chk("rst_noread", 32'(rd_ptr),     32'd0);

        // Stream five words back-to-back.
        m_ready = 1'b1; base = log_n; rst_n = 1'b1;
        wait_log(base + 5, 40, "stream_wait");
        for (int i = 0; i < 5; i++) begin
            chk("stream_data", 32'(log_d[base+i]), 32'(exp_s[i]));
            chk("stream_last", 32'(log_l[base+i]), 32'(i == 3));
        end
        chk("stream_b2b",    32'(log_c[base+4] - log_c[base]), 32'd4);
        chk("stream_wcount", 32'(word_count), 32'd5);
        chk("stream_busy",   32'(busy),       32'd1);
        tick(3);
        chk("empty_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("empty_valid", 32'(m_valid),    32'd0);
        chk("stream_once", 32'(log_n),      32'(base + 5));

        // Backpressure while 0x81 is at the head.
        rst_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(exp_s[i]);
        tick(2);
        base = log_n; rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1);
            if (m_valid && m_data == 8'h81) found = 1'b1;
        end
        chk("bp_head81", 32'(found), 32'd1);
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("bp_hold_data",  32'(m_data),     32'h81);
            chk("bp_hold_valid", 32'(m_valid),    32'd1);
            chk("bp_rd_en_low",  32'(fifo_rd_en), 32'd0);
        end
        m_ready = 1'b1;
        wait_log(base + 5, 30, "bp_wait");
        tick(3);
        chk("bp_count", 32'(log_n), 32'(base + 5));
        for (int i = 0; i < 5; i++) chk("bp_data", 32'(log_d[base+i]), 32'(exp_s[i]));
        chk("bp_last", 32'(log_l[base+3]), 32'd1);

        // Drain: drop enable with two words buffered.
        rst_n = 1'b0; enable = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(exp_s[i]);
        tick(2);
        base = log_n; rp0 = rd_ptr; rst_n = 1'b1;
        tick(6);
        chk("drain_pre_valid", 32'(m_valid), 32'd1);
        chk("drain_pre_data",  32'(m_data),  32'h24);
        enable = 1'b0; m_ready = 1'b1;
        #1;
        chk("drain_rd_en", 32'(fifo_rd_en), 32'd0);
        wait_log(base + 2, 10, "drain_wait");
        tick(2);
        chk("drain_busy",  32'(busy),            32'd0);
        chk("drain_valid", 32'(m_valid),         32'd0);
        chk("drain_count", 32'(log_n),           32'(base + 2));
        chk("drain_d0",    32'(log_d[base]),     32'h24);
        chk("drain_d1",    32'(log_d[base+1]),   32'h81);
        chk("drain_reads", 32'(rd_ptr - rp0),    32'd2);

        // Word counter wrap (FIFO still holds 0x09, 0x63, 0x0D).
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        force dut.r_word_count = 16'hFFFF;
        #1;
        release dut.r_word_count;
        #1;
        chk("wrap_preset", 32'(word_count), 32'h0000FFFF);
        base = log_n; enable = 1'b1; m_ready = 1'b1;
        wait_log(base + 1, 20, "wrap_wait");
        m_ready = 1'b0;
        chk("wrap_wcount", 32'(word_count), 32'd0);
        chk("wrap_data",   32'(log_d[base]), 32'h09);

        // Reset while 0x63 and 0x0D sit in the buffer.
        tick(4);
        chk("mid_pre_valid", 32'(m_valid), 32'd1);
        chk("mid_pre_data",  32'(m_data),  32'h63);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(m_valid),    32'd0);
        chk("mid_rst_data",   32'(m_data),     32'd0);
        chk("mid_rst_last",   32'(m_last),     32'd0);
        chk("mid_rst_busy",   32'(busy),       32'd0);
        chk("mid_rst_wcount", 32'(word_count), 32'd0);
        chk("mid_rst_rd_en",  32'(fifo_rd_en), 32'd0);
        for (int i = 0; i < 4; i++) push_word(exp_r[i]);
        tick(2);
        base = log_n; m_ready = 1'b1; rst_n = 1'b1;
        wait_log(base + 4, 30, "mid_wait");
        tick(3);
        chk("mid_count", 32'(log_n), 32'(base + 4));
        for (int i = 0; i < 4; i++) begin
            chk("mid_data", 32'(log_d[base+i]), 32'(exp_r[i]));
            chk("mid_last", 32'(log_l[base+i]), 32'(i == 3));
        end

        chk("no_read_when_empty", 32'(rd_empty_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_stream_reader
